// File: rtl/rope_electro_if.sv
// Handshake bundle between the frame timer/game logic and the rope electrification scheduler.
// The master drives frame timing and the enable; the slave reports per-rope status.
interface rope_electro_if #(
   parameter int unsigned ROPES = 6
);
   logic                  startOfFrame;
   logic                  enable;
   logic [ROPES-1:0][1:0] electroStatus;
   logic [3:0]            activeCount;
   logic                  sparkPulse;

   modport master (
      output startOfFrame,
      output enable,
      input  electroStatus,
      input  activeCount,
      input  sparkPulse
   );

   modport slave (
      input  startOfFrame,
      input  enable,
      output electroStatus,
      output activeCount,
      output sparkPulse
   );
endinterface

// File: rtl/rope_electro_scheduler.sv
// Arms idle ropes one at a time and sequences each through WARN -> LIVE -> IDLE in frames.
// Define ELECTRO_LFSR_EN to start the idle-rope search from an LFSR instead of round-robin.
module rope_electro_scheduler #(
   parameter int unsigned ROPES       = 6,
   parameter int unsigned WARN_FRAMES = 45,
   parameter int unsigned LIVE_FRAMES = 90,
   parameter int unsigned GAP_FRAMES  = 60,
   parameter int unsigned MAX_LIVE    = 2
) (
   input  logic         clk,
   input  logic         resetN,
   rope_electro_if.slave bus
);

   localparam int unsigned PtrW    = (ROPES > 1) ? $clog2(ROPES) : 1;
   localparam logic [7:0]  WarnLd  = 8'(WARN_FRAMES - 1);
   localparam logic [7:0]  LiveLd  = 8'(LIVE_FRAMES - 1);
   localparam logic [7:0]  GapMax  = 8'(GAP_FRAMES - 1);
   localparam logic [3:0]  MaxLive = 4'(MAX_LIVE);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWarn = 2'b01,
      StLive = 2'b10
   } rope_state_e;

   rope_state_e      state_q [ROPES];
   logic [7:0]       cnt_q   [ROPES];
   logic [7:0]       gap_q;
   logic [3:0]       active_q, active_d;
   logic             spark_q;
`ifdef ELECTRO_LFSR_EN
   logic [7:0]       lfsr_q;
`else
   logic [PtrW-1:0]  ptr_q;
`endif

   logic             gap_full;
   logic             found;
   logic             launch;
   logic [PtrW-1:0]  pick;
   logic [PtrW-1:0]  idx;
   int unsigned      start_i;

   // Launch decision and next active count, both taken from the pre-edge state registers.
   always_comb begin
`ifdef ELECTRO_LFSR_EN
      start_i = 32'(lfsr_q) % ROPES;
`else
      start_i = 32'(ptr_q);
`endif
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < ROPES; i++) begin
         idx = PtrW'((start_i + i) % ROPES);
         if (!found && state_q[idx] == StIdle) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      gap_full = (gap_q >= GapMax);
      launch   = bus.startOfFrame && gap_full && bus.enable && (active_q < MaxLive) && found;

      active_d = '0;
      for (int r = 0; r < ROPES; r++) begin
         unique case (state_q[r])
            StIdle:  if (launch && pick == PtrW'(r)) active_d = active_d + 4'd1;
            StWarn:  active_d = active_d + 4'd1;
            StLive:  if (!bus.startOfFrame || cnt_q[r] != 8'd0) active_d = active_d + 4'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int r = 0; r < ROPES; r++) begin
            state_q[r] <= StIdle;
            cnt_q[r]   <= 8'd0;
         end
         gap_q    <= 8'd0;
         active_q <= 4'd0;
         spark_q  <= 1'b0;
`ifdef ELECTRO_LFSR_EN
         lfsr_q   <= 8'hA5;
`else
         ptr_q    <= '0;
`endif
      end else begin
         active_q <= active_d;
         spark_q  <= 1'b0;
         if (bus.startOfFrame) begin
`ifdef ELECTRO_LFSR_EN
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
            if (launch) ptr_q <= (pick == PtrW'(ROPES - 1)) ? '0 : pick + 1'b1;
`endif
            // A failed attempt leaves gap_q saturated so the launch retries next frame.
            if (launch)         gap_q <= 8'd0;
            else if (!gap_full) gap_q <= gap_q + 8'd1;

            for (int r = 0; r < ROPES; r++) begin
               unique case (state_q[r])
                  StIdle: begin
                     if (launch && pick == PtrW'(r)) begin
                        state_q[r] <= StWarn;
                        cnt_q[r]   <= WarnLd;
                     end
                  end
                  StWarn: begin
                     if (cnt_q[r] == 8'd0) begin
                        state_q[r] <= StLive;
                        cnt_q[r]   <= LiveLd;
                        spark_q    <= 1'b1;
                     end else begin
                        cnt_q[r] <= cnt_q[r] - 8'd1;
                     end
                  end
                  StLive: begin
                     if (cnt_q[r] == 8'd0) state_q[r] <= StIdle;
                     else                  cnt_q[r]   <= cnt_q[r] - 8'd1;
                  end
                  default: state_q[r] <= StIdle;
               endcase
            end
         end
      end
   end

   always_comb begin
      bus.electroStatus = '0;
      for (int r = 0; r < ROPES; r++) bus.electroStatus[r] = state_q[r];
   end

   assign bus.activeCount = active_q;
   assign bus.sparkPulse  = spark_q;

endmodule

// File: tb/tb_rope_electro_scheduler.sv
// Randomized bench for rope_electro_scheduler; the reference model tracks each rope by the
// frame it was launched in and derives its phase from the elapsed frame count.
module tb_rope_electro_scheduler;

   localparam int ROPES = 6;
   localparam int WARN  = 2;
   localparam int LIVE  = 3;
   localparam int GAP   = 4;
   localparam int MAXL  = 2;

   logic clk    = 1'b0;
   logic resetN = 1'b0;

   rope_electro_if #(.ROPES(ROPES)) bus ();

   rope_electro_scheduler #(
      .ROPES      (ROPES),
      .WARN_FRAMES(WARN),
      .LIVE_FRAMES(LIVE),
      .GAP_FRAMES (GAP),
      .MAX_LIVE   (MAXL)
   ) dut (
      .clk   (clk),
      .resetN(resetN),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int lf [ROPES];   // frame number in which each rope was last launched
   int gap;
   int ptr;
   int fr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s frame=%0d got=%0h exp=%0h", tag, fr, got, exp);
      end
   endtask

   // 0 idle, 1 warn, 2 live after the edge of frame f
   function automatic int state_of(input int r, input int f);
      int age;
      age = f - lf[r];
      if (age < 0)           return 0;
      if (age < WARN)        return 1;
      if (age < WARN + LIVE) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] exp_status(input int f);
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < ROPES; r++) v[r*2 +: 2] = 2'(state_of(r, f));
      return v;
   endfunction

   function automatic int exp_active(input int f);
      int n;
      n = 0;
      for (int r = 0; r < ROPES; r++) if (state_of(r, f) != 0) n++;
      return n;
   endfunction

   function automatic int exp_spark(input int f);
      for (int r = 0; r < ROPES; r++) if (f - lf[r] == WARN) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < ROPES; r++) lf[r] = -1000;
      gap = 0;
      ptr = 0;
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_status"}, 32'(bus.electroStatus), 32'd0);
      check_eq({tag, "_active"}, 32'(bus.activeCount), 32'd0);
      check_eq({tag, "_spark"}, 32'(bus.sparkPulse), 32'd0);
   endtask

   task automatic frame(input logic en);
      int pick;
      int r;
      @(negedge clk);
      bus.enable       = en;
      bus.startOfFrame = 1'b1;
      if (gap < GAP - 1) begin
         gap++;
      end else if (en && exp_active(fr) < MAXL) begin
         pick = -1;
         for (int i = 0; i < ROPES; i++) begin
            r = (ptr + i) % ROPES;
            if (pick < 0 && state_of(r, fr) == 0) pick = r;
         end
         if (pick >= 0) begin
            lf[pick] = fr + 1;
            ptr      = (pick + 1) % ROPES;
            gap      = 0;
         end
      end
      fr++;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      check_eq("status", 32'(bus.electroStatus), exp_status(fr));
      check_eq("active", 32'(bus.activeCount), 32'(exp_active(fr)));
      check_eq("spark", 32'(bus.sparkPulse), 32'(exp_spark(fr)));
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         check_eq("spark_width", 32'(bus.sparkPulse), 32'd0);
         check_eq("status_hold", 32'(bus.electroStatus), exp_status(fr));
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 resetN = 1'b0;
      #1 check_zero("rst_async");
      model_reset();
      repeat (3) begin
         @(negedge clk);
         bus.startOfFrame = ~bus.startOfFrame;
         check_zero("rst_hold");
      end
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      resetN           = 1'b1;
   endtask

   initial begin
      bus.startOfFrame = 1'b0;
      bus.enable       = 1'b0;
      fr               = 0;
      model_reset();
      repeat (4) begin
         @(negedge clk);
         bus.startOfFrame = ~bus.startOfFrame;
         bus.enable       = 1'b1;
         check_zero("reset");
      end
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      resetN           = 1'b1;

      // Continuous enable: single sequence, cap at MAX_LIVE, and round-robin wrap.
      repeat (60) frame(1'b1);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 39) == 0) async_reset();
         frame($urandom_range(0, 3) != 0);
      end

      repeat (12) frame(1'b0);
      repeat (12) frame(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
